// File: rtl/neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : neuron_layer_sequencer
// Purpose  : Time-multiplexes one neuron MAC over every neuron of a fully-
//            connected layer, streaming input/weight pairs from synchronous
//            RAMs and writing each neuron result to a result RAM.
//            Optional macro NEURON_SEQ_PAUSE_EN adds a 'pause' input that
//            stalls address issue while streaming.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_layer_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 10,
    parameter int IN_ADDR_W   = 10,
    parameter int W_ADDR_W    = 13,
    parameter int N_ADDR_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
`ifdef NEURON_SEQ_PAUSE_EN
    input  logic                  pause,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [IN_ADDR_W-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [W_ADDR_W-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [N_ADDR_W-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  neu_rst,
    output logic                  neu_valid,
    output logic [DATA_WIDTH-1:0] neu_data,
    output logic [DATA_WIDTH-1:0] neu_weight,
    output logic [DATA_WIDTH-1:0] neu_bias,
    input  logic                  neu_out_valid,
    input  logic [DATA_WIDTH-1:0] neu_out,
    output logic                  res_we,
    output logic [N_ADDR_W-1:0]   res_addr,
    output logic [DATA_WIDTH-1:0] res_data
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_STREAM = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_WRITE  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [IN_ADDR_W-1:0] c_LAST_I = IN_ADDR_W'(NUM_INPUTS - 1);
    localparam logic [N_ADDR_W-1:0]  c_LAST_N = N_ADDR_W'(NUM_NEURONS - 1);

    logic [2:0]            r_state;
    logic [IN_ADDR_W-1:0]  r_i;
    logic [N_ADDR_W-1:0]   r_n;
    logic [W_ADDR_W-1:0]   r_w_addr;
    logic                  r_neu_valid;
    logic                  r_neu_rst;
    logic [DATA_WIDTH-1:0] r_res_data;

    logic w_pause;
    logic w_issue;
    logic w_abort;

`ifdef NEURON_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    assign w_issue = (r_state == c_ST_STREAM) && !w_pause;
    assign w_abort = abort && (r_state != c_ST_IDLE);

    // The weight address is a running counter: it holds on the last beat of
    // each neuron and steps again on WRITE->STREAM, so it never passes the
    // final weight of the layer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_i         <= '0;
            r_n         <= '0;
            r_w_addr    <= '0;
            r_neu_valid <= 1'b0;
            r_neu_rst   <= 1'b1;
            r_res_data  <= '0;
        end else begin
            r_neu_rst   <= w_abort;
            r_neu_valid <= w_issue && !abort;
            if (w_abort) begin
                r_state  <= c_ST_IDLE;
                r_i      <= '0;
                r_n      <= '0;
                r_w_addr <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            r_state  <= c_ST_STREAM;
                            r_i      <= '0;
                            r_n      <= '0;
                            r_w_addr <= '0;
                        end
                    end
                    c_ST_STREAM: begin
                        if (!w_pause) begin
                            if (r_i == c_LAST_I) begin
                                r_i     <= '0;
                                r_state <= c_ST_WAIT;
                            end else begin
                                r_i      <= r_i + 1'b1;
                                r_w_addr <= r_w_addr + 1'b1;
                            end
                        end
                    end
                    c_ST_WAIT: begin
                        if (neu_out_valid) begin
                            r_res_data <= neu_out;
                            r_state    <= c_ST_WRITE;
                        end
                    end
                    c_ST_WRITE: begin
                        if (r_n == c_LAST_N) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_n      <= r_n + 1'b1;
                            r_w_addr <= r_w_addr + 1'b1;
                            r_state  <= c_ST_STREAM;
                        end
                    end
                    c_ST_DONE: begin
                        r_state  <= c_ST_IDLE;
                        r_i      <= '0;
                        r_n      <= '0;
                        r_w_addr <= '0;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign res_we     = (r_state == c_ST_WRITE);
    assign in_addr    = r_i;
    assign w_addr     = r_w_addr;
    assign b_addr     = r_n;
    assign res_addr   = r_n;
    assign res_data   = r_res_data;
    assign neu_rst    = r_neu_rst;
    assign neu_valid  = r_neu_valid;
    assign neu_data   = in_data;
    assign neu_weight = w_data;
    assign neu_bias   = b_data;

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_layer_sequencer
// Purpose  : Self-checking bench: RAM and neuron environment, a layer-timeline
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_layer_sequencer;

    localparam int NI    = 4;
    localparam int NN    = 3;
    localparam int LAYER = NN * (NI + 3);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic        busy, done, neu_rst, neu_valid, res_we;
    logic [1:0]  in_addr, b_addr, res_addr;
    logic [3:0]  w_addr;
    logic [15:0] in_data, w_data, b_data, neu_data, neu_weight, neu_bias, res_data;
    logic        neu_out_valid;
    logic [15:0] neu_out;

    logic [15:0] in_mem [NI];
    logic [15:0] w_mem  [NI*NN];
    logic [15:0] b_mem  [NN];
    logic [15:0] res_seen [NN];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_rise = 0, t_done = 0, busy_cnt = 0, done_cnt = 0, nv_cnt = 0, we_cnt = 0;
    bit busy_q = 1'b0;
    bit exp_we;

    bit m_active = 1'b0;
    int m_k = 0;
    bit m_issue_prev = 1'b0;
    bit m_rst_exp = 1'b1;
    int m_phase, m_n;

    always #5 clk = ~clk;

    neuron_layer_sequencer #(
        .DATA_WIDTH(16), .NUM_INPUTS(NI), .NUM_NEURONS(NN),
        .IN_ADDR_W(2), .W_ADDR_W(4), .N_ADDR_W(2)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef NEURON_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data),
        .neu_rst(neu_rst), .neu_valid(neu_valid),
        .neu_data(neu_data), .neu_weight(neu_weight), .neu_bias(neu_bias),
        .neu_out_valid(neu_out_valid), .neu_out(neu_out),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    function automatic longint prod(input logic [15:0] a, input logic [15:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic [15:0] sat15(input longint s);
        longint v;
        v = s >>> 15;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    // Expected neuron result straight from the arithmetic definition.
    function automatic logic [15:0] exp_res(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < NI; i++) s += prod(in_mem[i], w_mem[n*NI+i]);
        s += longint'($signed(b_mem[n])) <<< 15;
        return sat15(s);
    endfunction

    // Synchronous-read RAMs.
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        w_data  <= w_mem[w_addr];
        b_data  <= b_mem[b_addr];
    end

    // Neuron environment: accumulates NI qualified beats, bias on the last.
    longint acc;
    int     beat;
    always @(posedge clk) begin
        if (rst || neu_rst) begin
            acc <= 0; beat <= 0; neu_out_valid <= 1'b0; neu_out <= '0;
        end else begin
            neu_out_valid <= 1'b0;
            if (neu_valid) begin
                if (beat == NI-1) begin
                    neu_out_valid <= 1'b1;
                    neu_out <= sat15(acc + prod(neu_data, neu_weight)
                                     + (longint'($signed(neu_bias)) <<< 15));
                    acc <= 0; beat <= 0;
                end else begin
                    acc  <= acc + prod(neu_data, neu_weight);
                    beat <= beat + 1;
                end
            end
        end
    end

    // Layer timeline model: k counts cycles from the first STREAM cycle,
    // each neuron occupies NI+3 cycles, a paused issue slot stalls k.
    always_comb begin
        m_phase = m_k % (NI + 3);
        m_n     = m_k / (NI + 3);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0; m_k <= 0; m_issue_prev <= 1'b0; m_rst_exp <= 1'b1;
        end else begin
            m_rst_exp <= m_active && abort;
            if (!m_active) begin
                m_issue_prev <= 1'b0;
                if (start && !abort) begin m_active <= 1'b1; m_k <= 0; end
            end else if (abort || m_k == LAYER) begin
                m_active <= 1'b0; m_issue_prev <= 1'b0;
            end else begin
                m_issue_prev <= (m_phase < NI) && !pause;
                if (!((m_phase < NI) && pause)) m_k <= m_k + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 100) begin
            @(posedge clk); #1; c++;
        end
        chk(name, done, 1'b1);
    endtask

    task automatic run_layer(input string name);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(name);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_results(input string tag, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2);
        chk({tag, "_r0"}, res_seen[0], e0);
        chk({tag, "_r1"}, res_seen[1], e1);
        chk({tag, "_r2"}, res_seen[2], e2);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NN; i++) res_seen[i] = 16'hDEAD;
    endtask

    int s_busy, s_done, s_nv, s_we, t1, t2;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    exp_we = m_active && (m_k < LAYER) && (m_phase == NI + 2);
                    chk("busy", busy, m_active);
                    chk("done", done, m_active && (m_k == LAYER));
                    chk("res_we", res_we, exp_we);
                    chk("neu_valid", neu_valid, m_issue_prev);
                    chk("neu_rst", neu_rst, m_rst_exp);
                    if (exp_we) begin
                        chk("res_addr", res_addr, m_n);
                        chk("res_data", res_data, exp_res(m_n));
                    end
                    if (m_active && m_k < LAYER && m_phase < NI) begin
                        chk("w_addr", w_addr, m_n*NI + m_phase);
                        chk("in_addr", in_addr, m_phase);
                        chk("b_addr", b_addr, m_n);
                    end
                    if (busy && !busy_q) t_rise = cyc;
                    busy_q = busy;
                    if (busy) busy_cnt++;
                    if (done) begin done_cnt++; t_done = cyc; end
                    if (neu_valid) nv_cnt++;
                    if (res_we) begin we_cnt++; res_seen[res_addr] = res_data; end
                end
            end
        join_none

        for (int i = 0; i < NI; i++) in_mem[i] = 16'h4000;
        for (int i = 0; i < NI*NN; i++) w_mem[i] = 16'h4000;
        for (int i = 0; i < NN; i++) b_mem[i] = 16'h0000;
        clear_seen();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_neu_valid", neu_valid, 1'b0);
        chk("rst_res_we", res_we, 1'b0);
        chk("rst_w_addr", w_addr, 4'd0);
        chk("rst_res_data", res_data, 16'h0000);
        chk("rst_neu_rst", neu_rst, 1'b1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_neu_rst", neu_rst, 1'b0);

        // Layer with all 0x4000 operands: each neuron saturates to 0x7FFF.
        s_busy = busy_cnt; s_nv = nv_cnt; s_we = we_cnt;
        run_layer("l1_done");
        chk("l1_done_latency", t_done - t_rise, 21);
        chk("l1_busy_cycles", busy_cnt - s_busy, 22);
        chk("l1_beats", nv_cnt - s_nv, 12);
        chk("l1_writes", we_cnt - s_we, 3);
        chk_results("l1", 16'h7FFF, 16'h7FFF, 16'h7FFF);

        // Negative full-scale bias on neuron 1 cancels its sum.
        b_mem[1] = 16'h8000;
        clear_seen();
        run_layer("l2_done");
        chk_results("l2", 16'h7FFF, 16'h0000, 16'h7FFF);

        // Abort in the 2nd streaming cycle of neuron 1.
        clear_seen();
        s_done = done_cnt; s_we = we_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        chk("ab_busy_before", busy, 1'b1);
        @(posedge clk); #1 abort = 1'b0;
        chk("ab_busy_after", busy, 1'b0);
        chk("ab_neu_rst_hi", neu_rst, 1'b1);
        @(posedge clk); #1;
        chk("ab_neu_rst_lo", neu_rst, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("ab_no_done", done_cnt - s_done, 0);
        chk("ab_writes", we_cnt - s_we, 1);
        clear_seen();
        run_layer("ab_rerun_done");
        chk_results("ab_rerun", 16'h7FFF, 16'h0000, 16'h7FFF);

        // start held high across a whole layer: back-to-back runs, 23 apart.
        s_done = done_cnt; s_we = we_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        t1 = t_rise;
        repeat (29) @(posedge clk);
        #1 start = 1'b0;
        wait_done("hold_done");
        repeat (2) @(posedge clk);
        #1;
        t2 = t_rise;
        chk("hold_run_spacing", t2 - t1, 23);
        chk("hold_done_count", done_cnt - s_done, 2);
        chk("hold_writes", we_cnt - s_we, 6);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_idle_after", busy, 1'b0);

`ifdef NEURON_SEQ_PAUSE_EN
        // Pause for 3 cycles early in neuron 0: layer 3 cycles longer.
        clear_seen();
        s_nv = nv_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
        wait_done("pause_done");
        repeat (2) @(posedge clk);
        #1;
        chk("pause_latency", t_done - t_rise, 24);
        chk("pause_beats", nv_cnt - s_nv, 12);
        chk_results("pause", 16'h7FFF, 16'h0000, 16'h7FFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
